edge_frame_seq: RTL and testbench

Frame sequencer for the Sobel edge-detection stage. On a `start` pulse it reads one grayscale frame from a source frame buffer and streams it into the Sobel filter with vsync/hsync/de framing. It then appends flush pixels so the filter's line-buffer window drains, and writes the aligned filter output into a destination frame buffer. It sits between the capture frame buffer and the plotter-path edge buffer, and owns all Sobel timing.

---
 rtl/edge_seq_pkg.sv | 25 ++
 rtl/edge_seq_writer.sv | 88 ++++++++
 rtl/edge_frame_seq.sv | 161 ++++++++++++++++
 tb/tb_edge_frame_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_seq_pkg.sv
// Shared definitions for the Sobel frame sequencer: FSM state encoding and
// the default frame geometry that the Sobel instance is built with.
package edge_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    LINE,
    HBLANK,
    FLUSH,
    DRAIN,
    DONE
  } edge_seq_state_t;

  localparam int EDGE_WIDTH      = 8;
  localparam int EDGE_H_RES      = 176;
  localparam int EDGE_V_RES      = 144;
  localparam int EDGE_H_BLANK    = 16;
  localparam int EDGE_V_SYNC_CYC = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_seq_writer.sv
// Destination writer: drops the first SKIP filter samples, then writes exactly
// H_RES*V_RES pixels. EDGE_SEQ_BORDER_CLEAR_EN zeroes the outermost rows/columns.
module edge_seq_writer
  import edge_seq_pkg::*;
#(
  parameter int WIDTH  = EDGE_WIDTH,
  parameter int H_RES  = EDGE_H_RES,
  parameter int V_RES  = EDGE_V_RES,
  parameter int SKIP   = H_RES + 2,
  parameter int ADDR_W = $clog2(H_RES * V_RES)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              pix_vld,
  input  logic [WIDTH-1:0]  pix_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              complete
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TOTAL = H_RES * V_RES + SKIP;

  logic [CNT_W-1:0] out_cnt;
  logic             keep;
  logic [WIDTH-1:0] data_in;

  // Counting freezes at TOTAL, so stray samples after the frame never write.
  assign complete = (out_cnt == CNT_W'(TOTAL));
  assign keep     = (out_cnt >= CNT_W'(SKIP));

`ifdef EDGE_SEQ_BORDER_CLEAR_EN
  localparam int COL_W = $clog2(H_RES + 1);
  localparam int ROW_W = $clog2(V_RES + 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_end;
  logic             border;

  assign col_end = (col == COL_W'(H_RES - 1));
  assign border  = (row == '0) || (row == ROW_W'(V_RES - 1)) ||
                   (col == '0) || col_end;
  assign data_in = border ? '0 : pix_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (pix_vld && !complete && keep) begin
      col <= col_end ? '0 : col + COL_W'(1);
      if (col_end) begin
        row <= (row == ROW_W'(V_RES - 1)) ? '0 : row + ROW_W'(1);
      end
    end
  end
`else
  assign data_in = pix_data;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_cnt <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (clear) begin
      out_cnt <= '0;
      wr_en   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (pix_vld && !complete) begin
        out_cnt <= out_cnt + CNT_W'(1);
        if (keep) begin
          wr_en   <= 1'b1;
          wr_addr <= ADDR_W'(out_cnt - CNT_W'(SKIP));
          wr_data <= data_in;
        end
      end
    end
  end

endmodule

// File: rtl/edge_frame_seq.sv
// Sobel frame sequencer: reads a source frame, frames it for the filter, flushes
// the window and stores the aligned result. Option: EDGE_SEQ_BORDER_CLEAR_EN.
module edge_frame_seq
  import edge_seq_pkg::*;
#(
  parameter int WIDTH      = EDGE_WIDTH,
  parameter int H_RES      = EDGE_H_RES,
  parameter int V_RES      = EDGE_V_RES,
  parameter int H_BLANK    = EDGE_H_BLANK,
  parameter int V_SYNC_CYC = EDGE_V_SYNC_CYC,
  parameter int SKIP       = H_RES + 2,
  parameter int ADDR_W     = $clog2(H_RES * V_RES)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_rd_addr,
  input  logic [WIDTH-1:0]  src_rd_data,
  output logic              f_vsync,
  output logic              f_hsync,
  output logic              f_de,
  output logic [WIDTH-1:0]  f_data,
  input  logic              f_o_de,
  input  logic [WIDTH-1:0]  f_o_data,
  output logic              dst_wr_en,
  output logic [ADDR_W-1:0] dst_wr_addr,
  output logic [WIDTH-1:0]  dst_wr_data
);

  localparam int CNT_W  = $clog2(max_int(max_int(V_SYNC_CYC, H_BLANK), SKIP)) + 1;
  localparam int PIX_W  = $clog2(H_RES + 1);
  localparam int LINE_W = $clog2(V_RES + 1);

  edge_seq_state_t   state;
  edge_seq_state_t   next_state;
  logic [CNT_W-1:0]  phase_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic              line_end;
  logic              last_line;
  logic              phase_end;
  logic              rd_d;
  logic              valid_d;
  logic              hsync_d;
  logic              clear;
  logic              wr_complete;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    line_end   = (pix_cnt == PIX_W'(H_RES - 1));
    last_line  = (line_cnt == LINE_W'(V_RES - 1));
    phase_end  = 1'b0;
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = VSYNC;
      end
      VSYNC: begin
        phase_end = (phase_cnt == CNT_W'(V_SYNC_CYC - 1));
        if (phase_end) next_state = LINE;
      end
      LINE: begin
        if (line_end) next_state = last_line ? FLUSH : HBLANK;
      end
      HBLANK: begin
        phase_end = (phase_cnt == CNT_W'(H_BLANK - 1));
        if (phase_end) next_state = LINE;
      end
      FLUSH: begin
        phase_end = (phase_cnt == CNT_W'(SKIP - 1));
        if (phase_end) next_state = DRAIN;
      end
      DRAIN: begin
        if (wr_complete) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);
  assign src_rd_en   = (state == LINE);
  assign src_rd_addr = rd_addr;
  assign f_vsync     = (state == VSYNC);
  assign clear       = (state == IDLE) && start;

  // The phase counter restarts on every state change and times VSYNC, HBLANK and FLUSH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_cnt <= '0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      rd_addr   <= '0;
    end else begin
      if (next_state != state) begin
        phase_cnt <= '0;
      end else if (state inside {VSYNC, HBLANK, FLUSH}) begin
        phase_cnt <= phase_cnt + CNT_W'(1);
      end
      if (state == LINE) begin
        pix_cnt <= line_end ? '0 : pix_cnt + PIX_W'(1);
        if (line_end) begin
          line_cnt <= last_line ? '0 : line_cnt + LINE_W'(1);
        end
        rd_addr <= (line_end && last_line) ? '0 : rd_addr + ADDR_W'(1);
      end
    end
  end

  // Framing is delayed one cycle so it lines up with the registered source data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_d    <= 1'b0;
      valid_d <= 1'b0;
      hsync_d <= 1'b0;
    end else begin
      rd_d    <= src_rd_en;
      valid_d <= src_rd_en || (state == FLUSH);
      hsync_d <= (state == HBLANK);
    end
  end

  assign f_de    = valid_d;
  assign f_hsync = hsync_d;
  assign f_data  = rd_d ? src_rd_data : '0;

  edge_seq_writer #(
    .WIDTH  (WIDTH),
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .SKIP   (SKIP),
    .ADDR_W (ADDR_W)
  ) u_writer (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (clear),
    .pix_vld  (f_o_de),
    .pix_data (f_o_data),
    .wr_en    (dst_wr_en),
    .wr_addr  (dst_wr_addr),
    .wr_data  (dst_wr_data),
    .complete (wr_complete)
  );

endmodule

// File: tb/tb_edge_frame_seq.sv
// Testbench for edge_frame_seq on an 8x4 frame with a behavioural Sobel filter
// and source buffer; honours EDGE_SEQ_BORDER_CLEAR_EN for the expected image.
module tb_edge_frame_seq;

  localparam int WIDTH      = 8;
  localparam int H_RES      = 8;
  localparam int V_RES      = 4;
  localparam int H_BLANK    = 2;
  localparam int V_SYNC_CYC = 2;
  localparam int SKIP       = 10;
  localparam int ADDR_W     = 5;
  localparam int N          = H_RES * V_RES;
`ifdef EDGE_SEQ_BORDER_CLEAR_EN
  localparam bit BORDER_CLEAR = 1'b1;
`else
  localparam bit BORDER_CLEAR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, src_rd_en;
  logic [ADDR_W-1:0] src_rd_addr;
  logic [WIDTH-1:0]  src_rd_data = '0;
  logic              f_vsync, f_hsync, f_de;
  logic [WIDTH-1:0]  f_data;
  logic              f_o_de;
  logic [WIDTH-1:0]  f_o_data;
  logic              dst_wr_en;
  logic [ADDR_W-1:0] dst_wr_addr;
  logic [WIDTH-1:0]  dst_wr_data;

  always #5 clk = ~clk;

  edge_frame_seq #(
    .WIDTH(WIDTH), .H_RES(H_RES), .V_RES(V_RES), .H_BLANK(H_BLANK),
    .V_SYNC_CYC(V_SYNC_CYC), .SKIP(SKIP), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
    .f_vsync(f_vsync), .f_hsync(f_hsync), .f_de(f_de), .f_data(f_data),
    .f_o_de(f_o_de), .f_o_data(f_o_data),
    .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data)
  );

  logic [7:0] frame  [0:N-1];
  logic [7:0] stream [0:63];
  logic [5:0] s_cnt;

  // Source frame buffer with one cycle of read latency.
  always @(posedge clk) begin
    if (src_rd_en) src_rd_data <= frame[src_rd_addr];
  end

  // Pixel i of either the filter's received stream or the source frame, zero outside.
  function automatic int px(input bit from_stream, input int i);
    if (i < 0) return 0;
    if (from_stream) return (i < 64) ? int'(stream[i[5:0]]) : 0;
    return (i < N) ? int'(frame[i[4:0]]) : 0;
  endfunction

  function automatic int sobel_at(input bit fs, input int c);
    int gx, gy, m;
    gx = px(fs, c-H_RES+1) + 2*px(fs, c+1) + px(fs, c+H_RES+1)
       - px(fs, c-H_RES-1) - 2*px(fs, c-1) - px(fs, c+H_RES-1);
    gy = px(fs, c+H_RES-1) + 2*px(fs, c+H_RES) + px(fs, c+H_RES+1)
       - px(fs, c-H_RES-1) - 2*px(fs, c-H_RES) - px(fs, c-H_RES+1);
    m = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  // Behavioural Sobel: output sample k is the window centred SKIP samples back.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      f_o_de   <= 1'b0;
      f_o_data <= '0;
      s_cnt    <= '0;
    end else begin
      f_o_de <= f_de;
      if (f_vsync) begin
        s_cnt <= '0;
      end else if (f_de) begin
        stream[s_cnt] <= f_data;
        s_cnt         <= s_cnt + 6'd1;
        f_o_data      <= 8'(sobel_at(1'b1, int'(s_cnt) - SKIP));
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  int neg_cnt = 0;
  int start_neg = 0;
  int wr_idx, done_cnt, vs_cnt, de_cnt, hs_rise, hs_hi, rd_cnt, first_rd_cyc, last_wr_neg;
  bit prev_hs, prev_de, inject_en;
  int exp_img [0:N-1];
  int cap     [0:N-1];

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, actual, expected);
    end
  endtask

  // Per-cycle compare against the frame model; also injects stray start pulses.
  task automatic step();
    @(negedge clk);
    neg_cnt++;
    start = 1'b0;
    if (!rstn) return;
    if (src_rd_en) begin
      if (rd_cnt == 0) first_rd_cyc = neg_cnt - start_neg;
      checkOutput("src_rd_addr", int'(src_rd_addr), rd_cnt);
      rd_cnt++;
      if (inject_en && rd_cnt == 4) start = 1'b1;
    end
    if (inject_en && rd_cnt == N && prev_de && !f_de) start = 1'b1;
    if (f_vsync) vs_cnt++;
    if (f_de) de_cnt++;
    if (f_hsync) begin
      hs_hi++;
      if (!prev_hs) hs_rise++;
    end
    prev_hs = f_hsync;
    prev_de = f_de;
    if (dst_wr_en) begin
      checkOutput("dst_wr_addr", int'(dst_wr_addr), wr_idx);
      if (wr_idx < N) begin
        checkOutput("dst_wr_data", int'(dst_wr_data), exp_img[wr_idx]);
        cap[dst_wr_addr] = int'(dst_wr_data);
      end
      wr_idx++;
      last_wr_neg = neg_cnt;
    end
    if (done) begin
      done_cnt++;
      checkOutput("done_after_last_write", neg_cnt - last_wr_neg, 1);
      checkOutput("writes_at_done", wr_idx, N);
      checkOutput("busy_with_done", int'(busy), 0);
    end
  endtask

  task automatic load_frame(input bit step_img);
    for (int j = 0; j < N; j++) begin
      if (step_img) frame[j] = ((j % H_RES) >= 4) ? 8'hFF : 8'h00;
      else          frame[j] = 8'h40;
    end
    for (int j = 0; j < N; j++) begin
      int r, c;
      r = j / H_RES;
      c = j % H_RES;
      exp_img[j] = sobel_at(1'b0, j);
      if (BORDER_CLEAR && (r == 0 || r == V_RES-1 || c == 0 || c == H_RES-1)) exp_img[j] = 0;
      cap[j] = -1;
    end
  endtask

  task automatic reset_counts(input bit inject);
    wr_idx = 0; done_cnt = 0; vs_cnt = 0; de_cnt = 0; hs_rise = 0; hs_hi = 0;
    rd_cnt = 0; first_rd_cyc = -1; last_wr_neg = -10; prev_hs = 0; prev_de = 0;
    inject_en = inject;
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_src_rd_en"}, int'(src_rd_en), 0);
    checkOutput({tag, "_src_rd_addr"}, int'(src_rd_addr), 0);
    checkOutput({tag, "_f_vsync"}, int'(f_vsync), 0);
    checkOutput({tag, "_f_hsync"}, int'(f_hsync), 0);
    checkOutput({tag, "_f_de"}, int'(f_de), 0);
    checkOutput({tag, "_f_data"}, int'(f_data), 0);
    checkOutput({tag, "_dst_wr_en"}, int'(dst_wr_en), 0);
    checkOutput({tag, "_dst_wr_addr"}, int'(dst_wr_addr), 0);
  endtask

  // Runs one whole frame and checks the per-frame stream totals.
  task automatic applyStimulus(input bit step_img, input bit inject, input int tail);
    load_frame(step_img);
    reset_counts(inject);
    start = 1'b1;
    start_neg = neg_cnt;
    for (int i = 0; i < 400 && done_cnt == 0; i++) step();
    inject_en = 1'b0;
    repeat (tail) step();
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("write_count", wr_idx, N);
    checkOutput("read_count", rd_cnt, N);
    checkOutput("vsync_cycles", vs_cnt, V_SYNC_CYC);
    checkOutput("de_cycles", de_cnt, N + SKIP);
    checkOutput("hsync_pulses", hs_rise, V_RES - 1);
    checkOutput("hsync_cycles", hs_hi, (V_RES - 1) * H_BLANK);
    checkOutput("first_rd_cycle", first_rd_cyc, V_SYNC_CYC + 1);
  endtask

  initial begin
    $display("[TB] edge_frame_seq bench start (border clear = %0d)", BORDER_CLEAR);
    repeat (3) step();
    #1;
    check_all_zero("reset");
    rstn = 1'b1;
    repeat (2) step();

    // Flat frame: interior must be zero.
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("flat_model_r1c1", exp_img[9], 0);
    checkOutput("flat_r1c1", cap[9], 0);
    checkOutput("flat_r1c6", cap[14], 0);
    checkOutput("flat_r2c4", cap[20], 0);

    // Step frame with stray starts in LINE and DRAIN, then back-to-back repeat.
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("step_model_r1c3", exp_img[11], 255);
    checkOutput("step_r1c3", cap[11], 255);
    checkOutput("step_r1c4", cap[12], 255);
    checkOutput("step_r2c3", cap[19], 255);
    checkOutput("step_r2c4", cap[20], 255);
    checkOutput("step_r1c2", cap[10], 0);
    checkOutput("step_r2c5", cap[21], 0);
    applyStimulus(1'b1, 1'b0, 20);
    checkOutput("repeat_r1c4", cap[12], 255);
    checkOutput("repeat_r2c6", cap[22], 0);
`ifdef EDGE_SEQ_BORDER_CLEAR_EN
    checkOutput("border_r0c4", cap[4], 0);
    checkOutput("border_r3c3", cap[27], 0);
    checkOutput("border_r1c0", cap[8], 0);
    checkOutput("border_r2c7", cap[23], 0);
`endif

    // Reset in the middle of the first line aborts without done.
    load_frame(1'b0);
    reset_counts(1'b0);
    start = 1'b1;
    start_neg = neg_cnt;
    for (int i = 0; i < 50 && rd_cnt < 3; i++) step();
    checkOutput("abort_in_line", int'(src_rd_en), 1);
    rstn = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (3) step();
    checkOutput("abort_no_done", done_cnt, 0);
    checkOutput("abort_no_write", wr_idx, 0);
    rstn = 1'b1;
    repeat (2) step();
    applyStimulus(1'b1, 1'b0, 20);
    checkOutput("after_abort_r2c3", cap[19], 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
